// File: rtl/product_accumulator_if.sv
// product_accumulator_if: product input stream and group-sum output stream handshakes
interface product_accumulator_if #(parameter int PROD_W = 8, parameter int ACC_W = 12);
  logic in_valid;
  logic in_ready;
  logic [PROD_W-1:0] in_p;
  logic out_valid;
  logic out_ready;
  logic [ACC_W-1:0] out_sum;
  logic out_ovf;
  modport master(output in_valid, in_p, out_ready, input in_ready, out_valid, out_sum, out_ovf);
  modport slave(input in_valid, in_p, out_ready, output in_ready, out_valid, out_sum, out_ovf);
endinterface

// File: rtl/product_accumulator.sv
// product_accumulator: sums each group of TERMS products and holds the result until consumed
module product_accumulator #(
  parameter int PROD_W = 8,
  parameter int ACC_W = 12,
  parameter int TERMS = 4,
  localparam int CW = TERMS > 1 ? $clog2(TERMS) : 1
) (
  input logic clk,
  input logic rst,
  input logic clear,
  product_accumulator_if.slave bus,
  output logic [CW-1:0] term_cnt
);
  typedef enum logic {ACCUM, HOLD} state_t;
  state_t state, next;
  logic [ACC_W-1:0] acc;
  logic ovf;
  logic [ACC_W:0] sum;
  logic accept, last;
  assign bus.in_ready = state == ACCUM && !clear;
  assign bus.out_valid = state == HOLD;
  assign accept = bus.in_valid && bus.in_ready;
  assign last = term_cnt == CW'(TERMS - 1);
  assign sum = {1'b0, acc} + (ACC_W + 1)'(bus.in_p);
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ACCUM;
    else state <= next;
  // leave HOLD on handshake or clear; enter HOLD on the last term of a group
  always_comb begin
    next = state;
    next = state == ACCUM ? (accept && last ? HOLD : ACCUM) : (clear || bus.out_ready ? ACCUM : HOLD);
  end
  // running sum, carry flag and term count; result registers load on the last term
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc <= '0;
      ovf <= 1'b0;
      term_cnt <= '0;
      bus.out_sum <= '0;
      bus.out_ovf <= 1'b0;
    end else if (clear) begin
      acc <= '0;
      ovf <= 1'b0;
      term_cnt <= '0;
    end else if (accept && last) begin
      bus.out_sum <= sum[ACC_W-1:0];
      bus.out_ovf <= ovf | sum[ACC_W];
      acc <= '0;
      ovf <= 1'b0;
      term_cnt <= '0;
    end else if (accept) begin
      acc <= sum[ACC_W-1:0];
      ovf <= ovf | sum[ACC_W];
      term_cnt <= term_cnt + CW'(1);
    end
endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: table vectors plus corner sequences across three parameter sets
module tb_product_accumulator;
  typedef struct { int s; int o; } res_t;
  typedef struct { int k; int n; int p[5]; int s; int o; } vec_t;
  logic clk = 0, rst = 1;
  logic c0 = 0, c1 = 0, c2 = 0;
  logic [1:0] t0;
  logic [2:0] t1;
  logic t2;
  int checks = 0, errors = 0;
  res_t q0[$], q1[$], q2[$];
  res_t r0, r1, r2;
  vec_t tv[8];
  product_accumulator_if #(.PROD_W(8), .ACC_W(12)) b0();
  product_accumulator_if #(.PROD_W(8), .ACC_W(10)) b1();
  product_accumulator_if #(.PROD_W(8), .ACC_W(12)) b2();
  product_accumulator #(.PROD_W(8), .ACC_W(12), .TERMS(4)) u0(.clk(clk), .rst(rst), .clear(c0), .bus(b0.slave), .term_cnt(t0));
  product_accumulator #(.PROD_W(8), .ACC_W(10), .TERMS(5)) u1(.clk(clk), .rst(rst), .clear(c1), .bus(b1.slave), .term_cnt(t1));
  product_accumulator #(.PROD_W(8), .ACC_W(12), .TERMS(1)) u2(.clk(clk), .rst(rst), .clear(c2), .bus(b2.slave), .term_cnt(t2));
  always #5 clk = ~clk;
  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic unexpected(string nm, int s);
    checks++;
    errors++;
    $display("FAIL %s unexpected result sum=%0d at %0t", nm, s, $time);
  endtask
  // scoreboard pops on each accepted result; valid must never coexist with ready
  always @(negedge clk) begin
    if (b0.out_valid) chk("u0 ready while valid", b0.in_ready, 0);
    if (b0.out_valid && b0.out_ready && !c0) begin
      if (q0.size() == 0) unexpected("u0", b0.out_sum);
      else begin
        r0 = q0.pop_front();
        chk("u0 sum", b0.out_sum, r0.s);
        chk("u0 ovf", b0.out_ovf, r0.o);
      end
    end
  end
  always @(negedge clk) begin
    if (b1.out_valid && b1.out_ready && !c1) begin
      if (q1.size() == 0) unexpected("u1", b1.out_sum);
      else begin
        r1 = q1.pop_front();
        chk("u1 sum", b1.out_sum, r1.s);
        chk("u1 ovf", b1.out_ovf, r1.o);
      end
    end
  end
  always @(negedge clk) begin
    if (b2.out_valid) chk("u2 term_cnt", t2, 0);
    if (b2.out_valid && b2.out_ready && !c2) begin
      if (q2.size() == 0) unexpected("u2", b2.out_sum);
      else begin
        r2 = q2.pop_front();
        chk("u2 sum", b2.out_sum, r2.s);
        chk("u2 ovf", b2.out_ovf, r2.o);
      end
    end
  end
  task automatic drive(int k, logic v, int p);
    case (k)
      0: begin b0.in_valid = v; b0.in_p = 8'(p); end
      1: begin b1.in_valid = v; b1.in_p = 8'(p); end
      default: begin b2.in_valid = v; b2.in_p = 8'(p); end
    endcase
  endtask
  function automatic logic rdy(int k);
    return k == 0 ? b0.in_ready : k == 1 ? b1.in_ready : b2.in_ready;
  endfunction
  function automatic int qsize(int k);
    return k == 0 ? q0.size() : k == 1 ? q1.size() : q2.size();
  endfunction
  task automatic push(int k, int s, int o);
    res_t r;
    r.s = s;
    r.o = o;
    case (k)
      0: q0.push_back(r);
      1: q1.push_back(r);
      default: q2.push_back(r);
    endcase
  endtask
  task automatic send(int k, int p);
    int n = 0;
    drive(k, 1, p);
    @(negedge clk);
    while (!rdy(k) && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!rdy(k)) begin
      checks++;
      errors++;
      $display("FAIL send u%0d timed out waiting for in_ready", k);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic wait_empty(int k);
    int n = 0;
    while (qsize(k) != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain", qsize(k), 0);
    @(posedge clk);
    #1;
  endtask
  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    tv[0] = '{0, 4, '{225, 225, 225, 225, 0}, 900, 0};
    tv[1] = '{0, 4, '{1, 2, 3, 4, 0}, 10, 0};
    tv[2] = '{0, 4, '{255, 255, 255, 255, 0}, 1020, 0};
    tv[3] = '{1, 5, '{225, 225, 225, 225, 225}, 101, 1};
    tv[4] = '{1, 5, '{1, 1, 1, 1, 1}, 5, 0};
    tv[5] = '{2, 1, '{225, 0, 0, 0, 0}, 225, 0};
    tv[6] = '{2, 1, '{7, 0, 0, 0, 0}, 7, 0};
    tv[7] = '{1, 5, '{200, 0, 255, 17, 3}, 475, 0};
    for (int k = 0; k < 3; k++) drive(k, 0, 0);
    b0.out_ready = 1;
    b1.out_ready = 1;
    b2.out_ready = 1;
    #12;
    chk("rst out_valid", b0.out_valid, 0);
    chk("rst out_sum", b0.out_sum, 0);
    chk("rst out_ovf", b0.out_ovf, 0);
    chk("rst term_cnt", t0, 0);
    rst = 0;
    idle(1);
    chk("in_ready after rst", b0.in_ready, 1);
    for (int i = 0; i < 8; i++) begin
      push(tv[i].k, tv[i].s, tv[i].o);
      for (int j = 0; j < tv[i].n; j++) send(tv[i].k, tv[i].p[j]);
      drive(tv[i].k, 0, 0);
      wait_empty(tv[i].k);
      idle(2);
    end
    push(0, 900, 0);
    for (int j = 0; j < 4; j++) send(0, 225);
    drive(0, 0, 0);
    @(negedge clk);
    chk("latency out_valid", b0.out_valid, 1);
    chk("latency in_ready", b0.in_ready, 0);
    idle(1);
    @(negedge clk);
    chk("ready back", b0.in_ready, 1);
    chk("valid dropped", b0.out_valid, 0);
    idle(1);
    b0.out_ready = 0;
    push(0, 241, 0);
    send(0, 0);
    send(0, 15);
    send(0, 225);
    send(0, 1);
    drive(0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp valid", b0.out_valid, 1);
      chk("bp sum", b0.out_sum, 241);
      chk("bp ready", b0.in_ready, 0);
    end
    idle(1);
    b0.out_ready = 1;
    @(negedge clk);
    chk("bp ready at handshake", b0.in_ready, 0);
    idle(1);
    @(negedge clk);
    chk("bp ready after", b0.in_ready, 1);
    chk("bp drained", q0.size(), 0);
    idle(1);
    send(0, 100);
    send(0, 100);
    chk("term_cnt two", t0, 2);
    c0 = 1;
    drive(0, 1, 50);
    @(negedge clk);
    chk("clear blocks ready", b0.in_ready, 0);
    idle(1);
    c0 = 0;
    drive(0, 0, 0);
    @(negedge clk);
    chk("clear term_cnt", t0, 0);
    idle(1);
    push(0, 10, 0);
    for (int j = 1; j <= 4; j++) send(0, j);
    drive(0, 0, 0);
    wait_empty(0);
    for (int j = 0; j < 4; j++) send(0, 5);
    c0 = 1;
    drive(0, 0, 0);
    @(negedge clk);
    chk("hold clear valid before", b0.out_valid, 1);
    idle(1);
    c0 = 0;
    @(negedge clk);
    chk("hold clear valid", b0.out_valid, 0);
    chk("hold clear ready", b0.in_ready, 1);
    chk("hold clear no pop", q0.size(), 0);
    idle(1);
    send(0, 10);
    send(0, 20);
    drive(0, 0, 0);
    #1;
    chk("pre-rst term_cnt", t0, 2);
    rst = 1;
    #1;
    chk("async rst term_cnt", t0, 0);
    rst = 0;
    idle(1);
    b0.out_ready = 0;
    for (int j = 0; j < 4; j++) send(0, 9);
    drive(0, 0, 0);
    #1;
    chk("pre-rst valid", b0.out_valid, 1);
    rst = 1;
    #1;
    chk("async rst valid", b0.out_valid, 0);
    chk("async rst sum", b0.out_sum, 0);
    rst = 0;
    b0.out_ready = 1;
    idle(1);
    push(0, 12, 0);
    for (int j = 0; j < 4; j++) send(0, 3);
    drive(0, 0, 0);
    wait_empty(0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
